// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style execution blocks.
// Holds the ALU opcode constants, the default datapath width and the
// state encoding used by the iterative divider.
package mips_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_MUL  = 4'd11;
  localparam logic [3:0] ALU_DIV  = 4'd12;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } divState_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
//   remIn    : partial remainder, W+1 bits
//   inBit    : next dividend bit shifted into the remainder
//   divisor  : W-bit divisor
//   remOut   : partial remainder after the conditional subtract
//   qBit     : quotient bit produced by this iteration
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   remIn,
  input  logic         inBit,
  input  logic [W-1:0] divisor,
  output logic [W:0]   remOut,
  output logic         qBit
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // The shifted remainder is below 2*divisor, so a W+1 bit difference is
  // enough: bit W of the difference is set exactly when it borrowed.
  assign shifted = {remIn[W-1:0], inBit};
  assign diff    = shifted - {1'b0, divisor};
  assign qBit    = ~diff[W];
  assign remOut  = qBit ? diff : shifted;

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Build option: DIV_SIGNED_EN enables signed division when signedOp=1
// (magnitudes divided, quotient truncated toward zero, remainder takes
// the dividend sign). Without it signedOp is ignored.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : request a divide (sampled only in IDLE)
//   flush             : abort an in-flight divide, no done pulse
//   signedOp          : signed-divide select
//   a, b              : dividend, divisor
//   busy              : high in CALC and DONE
//   done              : one-cycle result-valid pulse
//   quotient/remainder: results, held until the next accepted start
//   divByZero         : b was zero; zeroFlag: quotient is zero
module div_unit
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              flush,
  input  logic              signedOp,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              divByZero,
  output logic              zeroFlag
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  divState_t         state, nextState;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W:0]   remReg;
  logic [DATA_W-1:0] qReg;
  logic [DATA_W-1:0] divisorReg;
  logic              negQ, negR;

  logic              aNeg, bNeg;
  logic [DATA_W-1:0] aMag, bMag;
  logic [DATA_W:0]   stepRem;
  logic              stepQ;
  logic [DATA_W-1:0] qNext, qFinal, rFinal;
  logic              lastStep;
  logic              bZero;

`ifdef DIV_SIGNED_EN
  // Operands are turned into magnitudes at the start edge; the result sign
  // is restored on the DONE entry edge, so latency matches the unsigned case.
  // The most-negative value maps onto itself, which as an unsigned magnitude
  // is correct, so most-negative / -1 falls out as most-negative, rem 0.
  assign aNeg = signedOp & a[DATA_W-1];
  assign bNeg = signedOp & b[DATA_W-1];
  assign aMag = aNeg ? -a : a;
  assign bMag = bNeg ? -b : b;
`else
  logic unusedSignedOp;
  assign unusedSignedOp = signedOp;
  assign aNeg = 1'b0;
  assign bNeg = 1'b0;
  assign aMag = a;
  assign bMag = b;
`endif

  assign bZero = (b == '0);

  // qReg starts as the dividend; each step consumes its MSB and shifts the
  // new quotient bit into the LSB, so it holds the quotient after DATA_W steps.
  div_step #(.W(DATA_W)) uStep (
    .remIn   (remReg),
    .inBit   (qReg[DATA_W-1]),
    .divisor (divisorReg),
    .remOut  (stepRem),
    .qBit    (stepQ)
  );

  assign qNext    = {qReg[DATA_W-2:0], stepQ};
  assign qFinal   = negQ ? -qNext : qNext;
  assign rFinal   = negR ? -stepRem[DATA_W-1:0] : stepRem[DATA_W-1:0];
  assign lastStep = (cnt == CNT_W'(DATA_W-1));

  always_comb begin
    nextState = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (start) nextState = bZero ? DIV_DONE : DIV_CALC;
      end
      DIV_CALC: begin
        busy = 1'b1;
        if (flush)         nextState = DIV_IDLE;
        else if (lastStep) nextState = DIV_DONE;
      end
      DIV_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        nextState = DIV_IDLE;
      end
      default: nextState = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DIV_IDLE;
      cnt        <= '0;
      remReg     <= '0;
      qReg       <= '0;
      divisorReg <= '0;
      negQ       <= 1'b0;
      negR       <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
      divByZero  <= 1'b0;
      zeroFlag   <= 1'b1;
    end else begin
      state <= nextState;
      case (state)
        DIV_IDLE: begin
          if (start) begin
            cnt        <= '0;
            remReg     <= '0;
            qReg       <= aMag;
            divisorReg <= bMag;
            negQ       <= aNeg ^ bNeg;
            negR       <= aNeg;
            // Divide by zero skips CALC: results land on this edge.
            if (bZero) begin
              quotient  <= '1;
              remainder <= a;
              divByZero <= 1'b1;
              zeroFlag  <= 1'b0;
            end
          end
        end
        DIV_CALC: begin
          if (!flush) begin
            remReg <= stepRem;
            qReg   <= qNext;
            cnt    <= cnt + 1'b1;
            if (lastStep) begin
              quotient  <= qFinal;
              remainder <= rFinal;
              divByZero <= 1'b0;
              zeroFlag  <= (qFinal == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit (DATA_W = 32).
module tb_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         flush;
  logic         signedOp;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         divByZero;
  logic         zeroFlag;

  int vecs = 0;
  int errs = 0;

  div_unit #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .flush     (flush),
    .signedOp  (signedOp),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .divByZero (divByZero),
    .zeroFlag  (zeroFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a start for one edge, then scramble the operands.
  task automatic startOp(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sv);
    @(negedge clk);
    start = 1'b1; a = av; b = bv; signedOp = sv;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  // Count edges after the start edge until done is seen (0 = the cycle
  // right after the start edge).
  task automatic waitDone(output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    while (lat < 100) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; flush = 0; signedOp = 0; a = 0; b = 0;
    #12;
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 ||
        divByZero !== 1'b0 || zeroFlag !== 1'b1) begin
      errs++;
      $display("FAIL reset: busy=%b done=%b q=%h r=%h dz=%b zf=%b, want 0 0 0 0 0 1",
               busy, done, quotient, remainder, divByZero, zeroFlag);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic checkDiv(input string nm, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic sv,
                          input int expLat, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input logic edz,
                          input logic ezf);
    int lat; bit ok;
    startOp(av, bv, sv);
    waitDone(lat, ok);
    vecs++;
    if (!ok || lat != expLat) begin
      errs++;
      $display("FAIL %s latency: got %0d (seen=%0b), want %0d", nm, lat, ok, expLat);
    end
    vecs++;
    if (quotient !== eq || remainder !== er || divByZero !== edz ||
        zeroFlag !== ezf || busy !== 1'b1) begin
      errs++;
      $display("FAIL %s result: q=%h r=%h dz=%b zf=%b busy=%b, want q=%h r=%h dz=%b zf=%b busy=1",
               nm, quotient, remainder, divByZero, zeroFlag, busy, eq, er, edz, ezf);
    end
    @(posedge clk); #1;
    vecs++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== eq || remainder !== er) begin
      errs++;
      $display("FAIL %s after: done=%b busy=%b q=%h r=%h, want done=0 busy=0 q=%h r=%h",
               nm, done, busy, quotient, remainder, eq, er);
    end
  endtask

  task automatic test_basic();
    checkDiv("100/7", 32'd100, 32'd7, 1'b0, W, 32'd14, 32'd2, 1'b0, 1'b0);
    checkDiv("max/16", 32'hFFFF_FFFF, 32'h10, 1'b0, W, 32'h0FFF_FFFF, 32'hF, 1'b0, 1'b0);
    checkDiv("9/9", 32'd9, 32'd9, 1'b0, W, 32'd1, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic test_div_zero();
    checkDiv("5/0", 32'd5, 32'd0, 1'b0, 0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
  endtask

  // 3/9 with a second start while busy and another while done is high.
  task automatic test_ignore();
    int doneCnt = 0;
    int doneAt = -1;
    bit busyBad = 1'b0;
    startOp(32'd3, 32'd9, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = (i == 10) || (i == 33);
      a = 32'd50; b = 32'd5;
      @(posedge clk); #1;
      if (done === 1'b1) begin doneCnt++; doneAt = i; end
      if ((i == 33 || i == 35 || i == 40) && busy !== 1'b0) busyBad = 1'b1;
    end
    start = 1'b0;
    vecs++;
    if (doneCnt != 1 || doneAt != W) begin
      errs++;
      $display("FAIL ignore_done: pulses=%0d at=%0d, want 1 at %0d", doneCnt, doneAt, W);
    end
    vecs++;
    if (quotient !== 32'd0 || remainder !== 32'd3 || zeroFlag !== 1'b1 || divByZero !== 1'b0) begin
      errs++;
      $display("FAIL ignore_result: q=%h r=%h zf=%b dz=%b, want 0 3 1 0",
               quotient, remainder, zeroFlag, divByZero);
    end
    vecs++;
    if (busyBad) begin
      errs++;
      $display("FAIL ignore_busy: start during done cycle was accepted, want busy=0");
    end
  endtask

  task automatic test_flush();
    bit sawDone = 1'b0;
    startOp(32'd1000, 32'd10, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      flush = (i == 15);
      @(posedge clk); #1;
      if (done === 1'b1) sawDone = 1'b1;
    end
    flush = 1'b0;
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL flush_busy: busy=%b, want 0", busy);
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) sawDone = 1'b1;
    end
    vecs++;
    if (sawDone || quotient !== 32'd0 || remainder !== 32'd3 || zeroFlag !== 1'b1) begin
      errs++;
      $display("FAIL flush_hold: done_seen=%b q=%h r=%h zf=%b, want 0 0 3 1",
               sawDone, quotient, remainder, zeroFlag);
    end
    checkDiv("1000/10", 32'd1000, 32'd10, 1'b0, W, 32'd100, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit sawDone = 1'b0;
    startOp(32'd1000, 32'd7, 1'b0);
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 ||
        divByZero !== 1'b0 || zeroFlag !== 1'b1) begin
      errs++;
      $display("FAIL reset_mid: busy=%b done=%b q=%h r=%h dz=%b zf=%b, want 0 0 0 0 0 1",
               busy, done, quotient, remainder, divByZero, zeroFlag);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) sawDone = 1'b1;
    end
    vecs++;
    if (sawDone) begin
      errs++;
      $display("FAIL reset_mid_discard: done/busy seen after reset, want none");
    end
    checkDiv("77/8", 32'd77, 32'd8, 1'b0, W, 32'd9, 32'd5, 1'b0, 1'b0);
  endtask

  task automatic test_signed();
`ifdef DIV_SIGNED_EN
    checkDiv("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, W, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    checkDiv("smin/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, W, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
    checkDiv("s7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, W, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
`else
    // signedOp has no effect: 0xFFFFFFF9 / 2 unsigned.
    checkDiv("u-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, W, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore();
    test_flush();
    test_reset_mid();
    test_signed();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
